pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Reset and lock controller that sits directly upstream and downstream of the core PLL.
- Drives the PLL `rst` input with a timed pulse and watches the asynchronous PLL `locked` output.
- Retries the PLL a bounded number of times if lock does not arrive.
- Releases the core reset only after lock has held stable for a set window; re-sequences on loss of lock or on a software relock request.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles that pll_rst is held high per attempt (≥1).
- LOCK_TIMEOUT_CYCLES, 74250: refclk cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 74.25 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before core reset release (≥1).
- MAX_RETRIES, 7: re-attempts after the first; range 0..15.

Ports:
- refclk  in  1  free-running 74.25 MHz reference clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock indication; asynchronous to refclk.
- relock_req  in  1  single-cycle synchronous request to restart the sequence.
- pll_rst  out  1  reset to the PLL.
- core_rst  out  1  reset to the logic clocked by PLL outputs; active high.
- pll_ready  out  1  high while in RUN.
- retry_count  out  4  retries consumed in the current sequence.
- lock_fail  out  1  sticky; high in FAIL.

Behaviour:
- Reset is asynchronous and active-high.
  - On rst: state=RESET_PLL, cnt=0, pll_rst=1, core_rst=1, pll_ready=0, retry_count=0, lock_fail=0, sync flops=0.
  - Takes effect immediately without a clock edge, including mid-operation.
- Lock synchronizer:
  - Two flops on refclk produce locked_s; latency 2 cycles.
  - All decisions use locked_s only.
- Outputs are registered and decoded from next-state: they change on the same edge as the state transition.
- cnt: single counter, width clog2(max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES))+1. Cleared on every state change.
- RESET_PLL:
  - pll_rst=1, core_rst=1.
  - cnt increments each cycle; when cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK.
  - pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles after each entry.
- WAIT_LOCK:
  - pll_rst=0, core_rst=1.
  - If locked_s=1, go to STABILIZE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1:
    - if retry_count==MAX_RETRIES, go to FAIL;
    - otherwise retry_count+1 and go to RESET_PLL.
- STABILIZE:
  - pll_rst=0, core_rst=1.
  - If locked_s=0, go to WAIT_LOCK; the timeout restarts from 0 and retry_count is unchanged.
  - If cnt==LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN.
- RUN:
  - core_rst=0, pll_ready=1, retry_count cleared to 0.
  - If locked_s=0, go to RESET_PLL: core_rst=1 and pll_ready=0 on that edge.
  - Worst-case core_rst assertion is 3 edges after pll_locked falls.
- FAIL:
  - pll_rst=1 and core_rst=1 held; lock_fail=1.
  - Leaves only on relock_req or rst.
- relock_req:
  - Valid in any state.
  - Goes to RESET_PLL with cnt=0, retry_count=0, lock_fail=0.
  - In RESET_PLL it restarts the pulse count.
- Priority, highest first: rst, relock_req, lock loss / lock arrival, timeout, count completion.
  - A timeout coinciding with locked_s=1 in WAIT_LOCK goes to STABILIZE.
- retry_count never exceeds MAX_RETRIES. No wrap.
- pll_rst and core_rst are glitch-free: driven directly from flops.

Test Plan (RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2):
1. Release rst; raise pll_locked 10 cycles after pll_rst falls.
   - pll_rst high 4 cycles.
   - locked_s 2 cycles after pll_locked rises.
   - core_rst falls and pll_ready rises after 8 further cycles.
   - retry_count=0.
2. pll_locked held 0.
   - Exactly 3 pll_rst pulses of 4 cycles, separated by 20-cycle waits.
   - retry_count steps 0→1→2.
   - Then lock_fail=1 and pll_rst=1 held indefinitely.
3. In STABILIZE at cnt=5, drop pll_locked for 1 cycle.
   - Returns to WAIT_LOCK; core_rst stays 1.
   - Release occurs only after 8 new consecutive lock cycles.
4. In RUN, drop pll_locked.
   - core_rst=1 and pll_ready=0 within 3 edges.
   - New 4-cycle pll_rst pulse; re-lock releases core_rst again.
5. From FAIL, pulse relock_req.
   - lock_fail=0 and retry_count=0 next edge.
   - Fresh 4-cycle pll_rst pulse.
6. Assert rst asynchronously mid-STABILIZE, between clock edges.
   - pll_rst=1, core_rst=1, pll_ready=0, lock_fail=0 immediately.
   - Sequence restarts cleanly after release.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a synchronized lock,
// and releases core reset only after lock has been stable. Bounded retries, sticky fail.
module pll_reset_sequencer #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 74250,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 7
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       core_rst,
   output logic       pll_ready,
   output logic [3:0] retry_count,
   output logic       lock_fail
);

   localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CNT = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
   localparam int CW      = $clog2(MAX_CNT) + 1;

   localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABILIZE,
      S_RUN,
      S_FAIL
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [3:0]      r_retry;
   logic [3:0]      w_retry_next;
   logic            w_restart;
   logic            w_cnt_clr;
   logic            w_counting;
   logic            r_sync1;
   logic            r_sync2;
   logic            w_locked_s;
   logic            r_pll_rst;
   logic            r_core_rst;
   logic            r_ready;
   logic            r_fail;

   // pll_locked is asynchronous to refclk; only the second flop is ever used.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   assign w_locked_s = r_sync2;

   always_comb begin
      w_next       = r_state;
      w_retry_next = r_retry;
      w_restart    = 1'b0;
      if (relock_req) begin
         w_next       = S_RESET_PLL;
         w_retry_next = '0;
         w_restart    = 1'b1;
      end else begin
         case (r_state)
            S_RESET_PLL: begin
               if (r_cnt == PULSE_LAST)
                  w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               if (w_locked_s) begin
                  w_next = S_STABILIZE;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  if (r_retry == RETRY_MAX) begin
                     w_next = S_FAIL;
                  end else begin
                     w_next       = S_RESET_PLL;
                     w_retry_next = r_retry + 4'd1;
                  end
               end
            end
            S_STABILIZE: begin
               if (!w_locked_s)
                  w_next = S_WAIT_LOCK;
               else if (r_cnt == STABLE_LAST)
                  w_next = S_RUN;
            end
            S_RUN: begin
               if (!w_locked_s)
                  w_next = S_RESET_PLL;
            end
            S_FAIL: begin
               w_next = S_FAIL;
            end
            default: begin
               w_next = S_RESET_PLL;
            end
         endcase
      end
      if (w_next == S_RUN)
         w_retry_next = '0;
   end

   // A relock in RESET_PLL stays in the same state but must still restart the pulse.
   assign w_cnt_clr  = w_restart || (w_next != r_state);
   assign w_counting = (r_state == S_RESET_PLL) || (r_state == S_WAIT_LOCK) ||
                       (r_state == S_STABILIZE);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state <= S_RESET_PLL;
         r_cnt   <= '0;
         r_retry <= '0;
      end else begin
         r_state <= w_next;
         r_retry <= w_retry_next;
         if (w_cnt_clr)
            r_cnt <= '0;
         else if (w_counting)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   // Outputs decoded from next-state so they move on the same edge as the state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_pll_rst  <= 1'b1;
         r_core_rst <= 1'b1;
         r_ready    <= 1'b0;
         r_fail     <= 1'b0;
      end else begin
         r_pll_rst  <= (w_next == S_RESET_PLL) || (w_next == S_FAIL);
         r_core_rst <= (w_next != S_RUN);
         r_ready    <= (w_next == S_RUN);
         r_fail     <= (w_next == S_FAIL);
      end
   end

   assign pll_rst     = r_pll_rst;
   assign core_rst    = r_core_rst;
   assign pll_ready   = r_ready;
   assign lock_fail   = r_fail;
   assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer: a phase/deadline reference model
// predicts every output each cycle; async resets are checked between edges.
module tb_pll_reset_sequencer;

   localparam int RSTP = 4;
   localparam int TOUT = 20;
   localparam int STAB = 8;
   localparam int MAXR = 2;

   localparam int P_PULSE = 0;
   localparam int P_WAIT  = 1;
   localparam int P_STAB  = 2;
   localparam int P_RUN   = 3;
   localparam int P_FAIL  = 4;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       core_rst;
   logic       pll_ready;
   logic [3:0] retry_count;
   logic       lock_fail;

   int n_chk;
   int n_err;

   // reference model: current phase, edge index at which its elapsed time is 0,
   // absolute edge counter, retries used, and the two-sample lock delay line
   int ph;
   int t_en;
   int n;
   int m_retry;
   logic h0;
   logic h1;

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES    (RSTP),
      .LOCK_TIMEOUT_CYCLES (TOUT),
      .LOCK_STABLE_CYCLES  (STAB),
      .MAX_RETRIES         (MAXR)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .relock_req  (relock_req),
      .pll_rst     (pll_rst),
      .core_rst    (core_rst),
      .pll_ready   (pll_ready),
      .retry_count (retry_count),
      .lock_fail   (lock_fail)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      ph      = P_PULSE;
      t_en    = n;
      m_retry = 0;
      h0      = 1'b0;
      h1      = 1'b0;
   endtask

   task automatic model_edge();
      int   el;
      int   np;
      int   nr;
      logic restart;
      logic ls;
      ls      = h1;
      el      = n - t_en;
      np      = ph;
      nr      = m_retry;
      restart = 1'b0;
      if (relock_req) begin
         np      = P_PULSE;
         nr      = 0;
         restart = 1'b1;
      end else begin
         case (ph)
            P_PULSE: if (el == RSTP - 1) np = P_WAIT;
            P_WAIT: begin
               if (ls) np = P_STAB;
               else if (el == TOUT - 1) begin
                  if (m_retry == MAXR) np = P_FAIL;
                  else begin
                     np = P_PULSE;
                     nr = m_retry + 1;
                  end
               end
            end
            P_STAB: begin
               if (!ls) np = P_WAIT;
               else if (el == STAB - 1) np = P_RUN;
            end
            P_RUN: if (!ls) np = P_PULSE;
            default: np = ph;
         endcase
      end
      if (np == P_RUN) nr = 0;
      if (np != ph || restart) t_en = n + 1;
      ph      = np;
      m_retry = nr;
      h1      = h0;
      h0      = pll_locked;
      n++;
   endtask

   task automatic check_outs();
      chk("pll_rst",     {31'd0, pll_rst},   {31'd0, (ph == P_PULSE) || (ph == P_FAIL)});
      chk("core_rst",    {31'd0, core_rst},  {31'd0, ph != P_RUN});
      chk("pll_ready",   {31'd0, pll_ready}, {31'd0, ph == P_RUN});
      chk("lock_fail",   {31'd0, lock_fail}, {31'd0, ph == P_FAIL});
      chk("retry_count", {28'd0, retry_count}, 32'(m_retry));
      if (m_retry > MAXR) chk("retry_bound", 32'(m_retry), 32'(MAXR));
   endtask

   task automatic step();
      @(posedge refclk);
      model_edge();
      @(negedge refclk);
      check_outs();
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic relock_pulse();
      relock_req = 1'b1;
      step();
      relock_req = 1'b0;
   endtask

   // assert rst between edges; outputs must change with no clock edge
   task automatic do_arst();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outs();
      @(posedge refclk);
      @(negedge refclk);
      check_outs();
      #1 rst = 1'b0;
   endtask

   initial begin
      int r;
      int len;
      n_chk      = 0;
      n_err      = 0;
      n          = 0;
      rst        = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      model_reset();
      repeat (3) @(posedge refclk);
      @(negedge refclk);
      check_outs();
      rst = 1'b0;

      // no lock: three attempts then FAIL, which must hold
      steps(90);
      // recover from FAIL, lock, reset asynchronously mid-STABILIZE
      relock_pulse();
      pll_locked = 1'b1;
      steps(8);
      do_arst();
      steps(30);
      // short glitch during STABILIZE, then lock loss from RUN
      pll_locked = 1'b0;
      steps(6);
      pll_locked = 1'b1;
      steps(10);
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      steps(30);
      pll_locked = 1'b0;
      steps(3);
      pll_locked = 1'b1;
      steps(30);

      for (int s = 0; s < 80; s++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1, 2, 3: begin
               pll_locked = 1'b1;
               len = int'($urandom_range(5, 40));
               steps(len);
            end
            4, 5: begin
               pll_locked = 1'b0;
               len = int'($urandom_range(5, 90));
               steps(len);
            end
            6: begin
               pll_locked = 1'b0;
               len = int'($urandom_range(1, 3));
               steps(len);
               pll_locked = 1'b1;
               steps(4);
            end
            7: relock_pulse();
            8: do_arst();
            default: begin
               for (int i = 0; i < 20; i++) begin
                  pll_locked = 1'($urandom_range(0, 1));
                  step();
               end
            end
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
